// File: rtl/l2_cache.sv
// Set-associative write-through L2 cache with block-granular L1 and memory ports.
// Read misses stall in MISS_WAIT until memory supplies the fill block.
module l2_cache #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 11,
    parameter int CACHE_SIZE    = 512,
    parameter int BLOCK_SIZE    = 32,
    parameter int NUM_WAYS      = 4,
    parameter int L1_BLOCK_SIZE = BLOCK_SIZE
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ADDR_WIDTH-1:0]               l1_cache_addr,
    input  logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0] l1_cache_data_in,
    input  logic                                l1_cache_read,
    input  logic                                l1_cache_write,
    output logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0] l1_block_data_out,
    output logic                                l1_block_valid,
    output logic                                l1_cache_ready,
    output logic                                l1_cache_hit,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0]    mem_data_block,
    input  logic                                mem_ready,
    output logic [ADDR_WIDTH-1:0]               mem_addr,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0]    mem_data_out,
    output logic                                mem_read,
    output logic                                mem_write
);

    localparam int BW    = BLOCK_SIZE * DATA_WIDTH;
    localparam int LINES = CACHE_SIZE / BLOCK_SIZE;
    localparam int SETS  = LINES / NUM_WAYS;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W;
    localparam int WAY_W = $clog2(NUM_WAYS);

    typedef enum logic {IDLE, MISS_WAIT} state_t;

    state_t                state;
    logic [NUM_WAYS-1:0]   valid  [SETS];
    logic [WAY_W-1:0]      rr_ptr [SETS];
    logic [TAG_W-1:0]      tags   [SETS][NUM_WAYS];
    logic [BW-1:0]         lines  [SETS][NUM_WAYS];
    logic [ADDR_WIDTH-1:0] miss_addr;
    logic [WAY_W-1:0]      miss_way;

    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      miss_idx;
    logic [TAG_W-1:0]      miss_tag;
    logic                  req_hit;
    logic [WAY_W-1:0]      hit_way;
    logic                  has_invalid;
    logic [WAY_W-1:0]      inv_way;
    logic [WAY_W-1:0]      victim_way;

    logic                  line_we;
    logic [IDX_W-1:0]      line_idx;
    logic [WAY_W-1:0]      line_way;
    logic [TAG_W-1:0]      line_tag;
    logic [BW-1:0]         line_data;

    assign req_idx  = l1_cache_addr[IDX_W-1:0];
    assign req_tag  = l1_cache_addr[ADDR_WIDTH-1:IDX_W];
    assign miss_idx = miss_addr[IDX_W-1:0];
    assign miss_tag = miss_addr[ADDR_WIDTH-1:IDX_W];

    // Tag match and victim choice for the set addressed by the current L1 request.
    always_comb begin
        req_hit     = 1'b0;
        hit_way     = '0;
        has_invalid = 1'b0;
        inv_way     = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (valid[req_idx][w] && tags[req_idx][w] == req_tag) begin
                req_hit = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!has_invalid && !valid[req_idx][w]) begin
                has_invalid = 1'b1;
                inv_way     = WAY_W'(w);
            end
        end
        victim_way = has_invalid ? inv_way : rr_ptr[req_idx];
    end

    // Single line-write port shared by L1 writes and memory fills.
    always_comb begin
        line_we   = 1'b0;
        line_idx  = req_idx;
        line_way  = victim_way;
        line_tag  = req_tag;
        line_data = l1_cache_data_in;
        if (!rst) begin
            if (state == IDLE && l1_cache_write) begin
                line_we  = 1'b1;
                line_way = req_hit ? hit_way : victim_way;
            end else if (state == MISS_WAIT && mem_ready) begin
                line_we   = 1'b1;
                line_idx  = miss_idx;
                line_way  = miss_way;
                line_tag  = miss_tag;
                line_data = mem_data_block;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tags[line_idx][line_way]  <= line_tag;
            lines[line_idx][line_way] <= line_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            l1_block_data_out <= '0;
            l1_block_valid    <= 1'b0;
            l1_cache_ready    <= 1'b0;
            l1_cache_hit      <= 1'b0;
            mem_addr          <= '0;
            mem_data_out      <= '0;
            mem_read          <= 1'b0;
            mem_write         <= 1'b0;
            miss_addr         <= '0;
            miss_way          <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid[s]  <= '0;
                rr_ptr[s] <= '0;
            end
        end else begin
            l1_block_valid <= 1'b0;
            l1_cache_ready <= 1'b0;
            l1_cache_hit   <= 1'b0;
            mem_write      <= 1'b0;
            if (line_we) begin
                valid[line_idx][line_way] <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (l1_cache_write) begin
                        if (!req_hit && !has_invalid) begin
                            rr_ptr[req_idx] <= rr_ptr[req_idx] + WAY_W'(1);
                        end
                        mem_write      <= 1'b1;
                        mem_addr       <= l1_cache_addr;
                        mem_data_out   <= l1_cache_data_in;
                        l1_cache_ready <= 1'b1;
                        l1_cache_hit   <= req_hit;
                    end else if (l1_cache_read) begin
                        if (req_hit) begin
                            l1_block_data_out <= lines[req_idx][hit_way];
                            l1_block_valid    <= 1'b1;
                            l1_cache_ready    <= 1'b1;
                            l1_cache_hit      <= 1'b1;
                        end else begin
                            if (!has_invalid) begin
                                rr_ptr[req_idx] <= rr_ptr[req_idx] + WAY_W'(1);
                            end
                            miss_addr <= l1_cache_addr;
                            miss_way  <= victim_way;
                            mem_read  <= 1'b1;
                            mem_addr  <= l1_cache_addr;
                            state     <= MISS_WAIT;
                        end
                    end
                end
                MISS_WAIT: begin
                    if (mem_ready) begin
                        l1_block_data_out <= mem_data_block;
                        l1_block_valid    <= 1'b1;
                        l1_cache_ready    <= 1'b1;
                        l1_cache_hit      <= 1'b0;
                        mem_read          <= 1'b0;
                        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_cache.sv
// Randomized bench for l2_cache: a memory image plus a residency/replacement
// model predict hit/miss and the data every read must return.
module tb_l2_cache;

    localparam int DW    = 32;
    localparam int AW    = 11;
    localparam int BS    = 32;
    localparam int BW    = DW * BS;
    localparam int WAYS  = 4;
    localparam int SETS  = 512 / BS / WAYS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] l1_cache_addr = '0;
    logic [BW-1:0] l1_cache_data_in = '0;
    logic          l1_cache_read = 1'b0;
    logic          l1_cache_write = 1'b0;
    logic [BW-1:0] l1_block_data_out;
    logic          l1_block_valid;
    logic          l1_cache_ready;
    logic          l1_cache_hit;
    logic [BW-1:0] mem_data_block = '0;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_data_out;
    logic          mem_read;
    logic          mem_write;

    l2_cache #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CACHE_SIZE(512),
        .BLOCK_SIZE(BS), .NUM_WAYS(WAYS), .L1_BLOCK_SIZE(BS)
    ) dut (
        .clk(clk), .rst(rst),
        .l1_cache_addr(l1_cache_addr), .l1_cache_data_in(l1_cache_data_in),
        .l1_cache_read(l1_cache_read), .l1_cache_write(l1_cache_write),
        .l1_block_data_out(l1_block_data_out), .l1_block_valid(l1_block_valid),
        .l1_cache_ready(l1_cache_ready), .l1_cache_hit(l1_cache_hit),
        .mem_data_block(mem_data_block), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_data_out(mem_data_out),
        .mem_read(mem_read), .mem_write(mem_write)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference: memory image (always current) plus which blocks are resident.
    logic [BW-1:0] mem_m [logic [AW-1:0]];
    bit            m_valid [SETS][WAYS];
    int            m_tag   [SETS][WAYS];
    int            m_ptr   [SETS];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_block(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        for (int i = 0; i < BS; i++)
            check($sformatf("%s[%0d]", tag, i), 64'(obs[i*DW +: DW]), 64'(exp[i*DW +: DW]));
    endtask

    function automatic logic [BW-1:0] rand_block();
        logic [BW-1:0] b;
        for (int i = 0; i < BS; i++) b[i*DW +: DW] = $urandom;
        return b;
    endfunction

    function automatic logic [BW-1:0] pattern_block(input logic [DW-1:0] base);
        logic [BW-1:0] b;
        for (int i = 0; i < BS; i++) b[i*DW +: DW] = base ^ DW'(i);
        return b;
    endfunction

    function automatic logic [BW-1:0] mem_get(input logic [AW-1:0] a);
        if (!mem_m.exists(a)) mem_m[a] = rand_block();
        return mem_m[a];
    endfunction

    function automatic bit m_resident(input logic [AW-1:0] a);
        int s = int'(a) % SETS;
        int t = int'(a) / SETS;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_install(input logic [AW-1:0] a);
        int s = int'(a) % SETS;
        int way = -1;
        for (int w = 0; w < WAYS; w++)
            if (way < 0 && !m_valid[s][w]) way = w;
        if (way < 0) begin
            way = m_ptr[s];
            m_ptr[s] = (m_ptr[s] + 1) % WAYS;
        end
        m_valid[s][way] = 1'b1;
        m_tag[s][way] = int'(a) / SETS;
    endtask

    task automatic m_clear();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_clear();
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int delay, input bit noise);
        bit h = m_resident(a);
        logic [BW-1:0] exp = mem_get(a);
        l1_cache_addr = a;
        l1_cache_read = 1'b1;
        @(posedge clk); #1;
        l1_cache_read = 1'b0;
        if (h) begin
            check("rd_hit_ready", l1_cache_ready, 1);
            check("rd_hit_valid", l1_block_valid, 1);
            check("rd_hit_hit", l1_cache_hit, 1);
            check("rd_hit_memread", mem_read, 0);
            check_block("rd_hit_data", l1_block_data_out, exp);
        end else begin
            check("rd_miss_memread", mem_read, 1);
            check("rd_miss_memaddr", mem_addr, a);
            check("rd_miss_ready", l1_cache_ready, 0);
            for (int d = 0; d < delay; d++) begin
                if (noise) begin
                    l1_cache_write = 1'b1;
                    l1_cache_addr = AW'($urandom);
                    l1_cache_data_in = rand_block();
                end
                @(posedge clk); #1;
                check("wait_memread", mem_read, 1);
                check("wait_memwrite", mem_write, 0);
                check("wait_ready", l1_cache_ready, 0);
            end
            mem_data_block = exp;
            mem_ready = 1'b1;
            @(posedge clk); #1;
            mem_ready = 1'b0;
            l1_cache_write = 1'b0;
            check("fill_ready", l1_cache_ready, 1);
            check("fill_valid", l1_block_valid, 1);
            check("fill_hit", l1_cache_hit, 0);
            check("fill_memread", mem_read, 0);
            check("fill_memwrite", mem_write, 0);
            check_block("fill_data", l1_block_data_out, exp);
            m_install(a);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [BW-1:0] d, input bit with_read);
        bit h = m_resident(a);
        l1_cache_addr = a;
        l1_cache_data_in = d;
        l1_cache_write = 1'b1;
        l1_cache_read = with_read;
        @(posedge clk); #1;
        l1_cache_write = 1'b0;
        l1_cache_read = 1'b0;
        check("wr_memwrite", mem_write, 1);
        check("wr_memaddr", mem_addr, a);
        check("wr_ready", l1_cache_ready, 1);
        check("wr_hit", l1_cache_hit, h);
        check("wr_valid", l1_block_valid, 0);
        check("wr_memread", mem_read, 0);
        check_block("wr_memdata", mem_data_out, d);
        if (!h) m_install(a);
        mem_m[a] = d;
    endtask

    task automatic idle_check();
        @(posedge clk); #1;
        check("idle_ready", l1_cache_ready, 0);
        check("idle_valid", l1_block_valid, 0);
        check("idle_hit", l1_cache_hit, 0);
        check("idle_memwrite", mem_write, 0);
        check("idle_memread", mem_read, 0);
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] ra;
        int op;

        @(posedge clk); #1;
        do_reset();
        check("rst_ready", l1_cache_ready, 0);
        check("rst_valid", l1_block_valid, 0);
        check("rst_hit", l1_cache_hit, 0);
        check("rst_memread", mem_read, 0);
        check("rst_memwrite", mem_write, 0);
        check("rst_memaddr", mem_addr, 0);
        check("rst_dout_w0", l1_block_data_out[DW-1:0], 0);
        check("rst_mdout_w0", mem_data_out[DW-1:0], 0);

        // Directed sequence.
        mem_m[11'h00A] = pattern_block(32'hDEADBEEF);
        do_read(11'h00A, 0, 0);
        idle_check();
        do_read(11'h00A, 0, 0);
        check("w0_0x00A", l1_block_data_out[DW-1:0], 32'hDEADBEEF);
        check("w31_0x00A", l1_block_data_out[31*DW +: DW], 32'hDEADBEF0);
        idle_check();
        do_write(11'h014, pattern_block(32'hA5A5A5A5), 0);
        do_read(11'h014, 0, 0);
        check("w0_0x014a", l1_block_data_out[DW-1:0], 32'hA5A5A5A5);
        do_write(11'h014, pattern_block(32'h5A5A5A5A), 0);
        do_write(11'h014, pattern_block(32'h11111111), 1);
        do_write(11'h014, pattern_block(32'h5A5A5A5A), 0);
        do_read(11'h014, 0, 0);
        check("w0_0x014b", l1_block_data_out[DW-1:0], 32'h5A5A5A5A);
        idle_check();

        do_reset();
        do_read(11'h000, 1, 0);
        do_read(11'h004, 2, 0);
        do_read(11'h008, 0, 1);
        do_read(11'h00C, 3, 1);
        do_read(11'h010, 1, 0);
        do_read(11'h004, 0, 0);
        check("hit_0x004", l1_cache_hit, 1);
        do_read(11'h000, 0, 0);
        check("miss_0x000", l1_cache_hit, 0);
        idle_check();

        // Reset while a fill is outstanding.
        l1_cache_addr = 11'h00A;
        l1_cache_read = 1'b1;
        @(posedge clk); #1;
        l1_cache_read = 1'b0;
        check("pre_rst_memread", mem_read, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_clear();
        check("abort_memread", mem_read, 0);
        mem_data_block = rand_block();
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        check("late_ready", l1_cache_ready, 0);
        check("late_valid", l1_block_valid, 0);
        do_read(11'h00A, 1, 0);
        check("post_rst_miss", l1_cache_hit, 0);

        // Random traffic over a small tag pool to exercise hits and replacement.
        for (int n = 0; n < 300; n++) begin
            ra = AW'(($urandom_range(0, 6) * SETS) + $urandom_range(0, SETS - 1));
            op = $urandom_range(0, 9);
            if (op < 5) do_read(ra, $urandom_range(0, 3), ($urandom_range(0, 2) == 0));
            else if (op < 9) do_write(ra, rand_block(), 0);
            else do_write(ra, rand_block(), 1);
            if ($urandom_range(0, 7) == 0) idle_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/l2_cache.md
# l2_cache

Set-associative, write-through, block-granular second-level cache between an L1 cache and main memory. L1 reads and writes whole blocks by block address. Read misses fetch a block from memory through a ready handshake. Every write is forwarded to memory in the same cycle it is accepted, and it allocates or updates the line in the cache.

## Interface
- `DATA_WIDTH`, 32: bits per word.
- `ADDR_WIDTH`, 11: block-address width (one address = one block).
- `CACHE_SIZE`, 512: total capacity in words; lines = CACHE_SIZE/BLOCK_SIZE; sets = lines/NUM_WAYS (default 16 lines, 4 sets).
- `BLOCK_SIZE`, 32: words per block.
- `NUM_WAYS`, 4: associativity.
- `L1_BLOCK_SIZE`, BLOCK_SIZE: words per L1 transfer; must equal BLOCK_SIZE.
- Block buses are packed BLOCK_SIZE×DATA_WIDTH; word i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `l1_cache_addr` in ADDR_WIDTH: block address; low log2(sets) bits = index, remaining bits = tag.
- `l1_cache_data_in` in BLOCK_SIZE×DATA_WIDTH: write block.
- `l1_cache_read` in 1: read request, sampled each edge while IDLE.
- `l1_cache_write` in 1: write request, sampled each edge while IDLE.
- `l1_block_data_out` out BLOCK_SIZE×DATA_WIDTH: read block.
- `l1_block_valid` out 1: l1_block_data_out valid (read completions only).
- `l1_cache_ready` out 1: request completed (one-cycle pulse).
- `l1_cache_hit` out 1: completed request hit; qualified by l1_cache_ready.
- `mem_data_block` in BLOCK_SIZE×DATA_WIDTH: fill data, valid with mem_ready.
- `mem_ready` in 1: memory fill data valid; sampled only in MISS_WAIT.
- `mem_addr` out ADDR_WIDTH: block address for mem_read or mem_write.
- `mem_data_out` out BLOCK_SIZE×DATA_WIDTH: write-through data.
- `mem_read` out 1: fill request, held high until mem_ready.
- `mem_write` out 1: write-through strobe, one-cycle pulse, no acknowledge.

## Operation
- Storage per line: valid bit, tag, BLOCK_SIZE words. Per set: round-robin victim pointer (log2(NUM_WAYS) bits).
- Lookup: hit when a valid way in the indexed set has a matching tag. At most one way can match.
- Victim selection: lowest-numbered invalid way. If all ways are valid, use the set's pointer, then increment it (wraps).
- States: IDLE and MISS_WAIT.
- IDLE, write (write has priority if read and write are both high):
  - Hit: overwrite that way's data.
  - Miss: install the block in the victim way (valid=1, tag written).
  - Same edge: mem_write=1, mem_addr=l1_cache_addr, mem_data_out=l1_cache_data_in, l1_cache_ready=1, l1_cache_hit=hit result, l1_block_valid=0.
- IDLE, read hit: l1_block_data_out=line data, l1_block_valid=1, l1_cache_ready=1, l1_cache_hit=1.
- IDLE, read miss:
  - Latch address and victim way.
  - Set mem_read=1 and mem_addr=address.
  - Go to MISS_WAIT.
- MISS_WAIT:
  - L1 requests are ignored.
  - On mem_ready=1: write mem_data_block into the victim way (valid, tag); l1_block_data_out=mem_data_block; l1_block_valid=1; l1_cache_ready=1; l1_cache_hit=0; mem_read=0; return to IDLE.
- No dirty bits and no write-back: memory is always current.

## Timing
- Reset values: all outputs 0, every valid bit 0, pointers 0, state IDLE. Reset in MISS_WAIT aborts the fill and drops mem_read at that edge.
- Hit and write latency: the response registers on the same edge that samples the request, so outputs are visible in the following cycle.
- Read miss: mem_read is high from the sampling edge onward. Completion registers on the edge where mem_ready=1 is sampled. Minimum latency is 2 edges.
- l1_cache_ready, l1_block_valid, l1_cache_hit and mem_write are single-cycle pulses, cleared on the next edge unless a new completion occurs.
- l1_block_data_out and mem_addr hold their last value between transactions.
- A request held high for several edges in IDLE is serviced once per edge.

## Test plan
- Reset, then read 0x00A -> one cycle later mem_read=1, mem_addr=0x00A. Drive mem_data_block[i]=0xDEADBEEF^i with mem_ready for one edge -> l1_block_valid=1, ready=1, hit=0, mem_read=0.
- Read 0x00A again -> next cycle valid=1, ready=1, hit=1, word0=0xDEADBEEF, word31=0xDEADBEF0; no mem_read.
- Write 0x014 with data 0xA5A5A5A5^i -> next cycle mem_write=1, mem_addr=0x014, ready=1, hit=0. A following read of 0x014 hits with word0=0xA5A5A5A5.
- Write 0x014 with 0x5A5A5A5A^i -> mem_write=1, ready=1, hit=1. A read of 0x014 returns word0=0x5A5A5A5A.
- Miss 5 distinct tags in index 0 (0x000, 0x004, 0x008, 0x00C, 0x010) -> the fifth replaces way 0. Re-reading 0x000 misses; 0x004 hits.
- Assert rst while in MISS_WAIT -> mem_read=0 next cycle. A late mem_ready has no effect, and 0x00A then misses.
